// File: rtl/delay_line_var.sv
// delay_line_var: multi-lane runtime-programmable delay pipeline with valid tracking,
// stall, flush and relock after a delay change.
module delay_line_var #(
    parameter int BITDATA = 8,
    parameter int LANES = 4,
    parameter int MAX_DELAY = 8,
    localparam int DW = $clog2(MAX_DELAY + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     flush,
    input  logic [DW-1:0]            delay_sel,
    input  logic                     din_valid,
    input  logic [LANES*BITDATA-1:0] din,
    output logic                     dout_valid,
    output logic [LANES*BITDATA-1:0] dout,
    output logic                     locked,
    output logic [DW-1:0]            delay_cur
);
    localparam int W = LANES * BITDATA;
    typedef enum logic {FILL, RUN} state_t;
    state_t state, state_nxt;
    logic [DW-1:0] cnt, cnt_nxt, delay_nxt, eff_sel;
    logic [MAX_DELAY-1:0] stage_v;
    logic [W-1:0] stage_d [MAX_DELAY];
    logic tap_v;
    always_comb eff_sel = (delay_sel == '0) ? DW'(1) :
                          (delay_sel > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : delay_sel;
    // A flush or delay change restarts the fill count; the coinciding edge never counts.
    always_comb begin
        state_nxt = state;
        cnt_nxt = cnt;
        delay_nxt = delay_cur;
        if (flush || eff_sel != delay_cur) begin
            state_nxt = FILL;
            cnt_nxt = eff_sel;
            delay_nxt = eff_sel;
        end else if (enable && state == FILL) begin
            if (cnt == DW'(1)) state_nxt = RUN;
            else cnt_nxt = cnt - 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            cnt <= DW'(1);
            delay_cur <= DW'(1);
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            delay_cur <= delay_nxt;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_v <= '0;
            for (int i = 0; i < MAX_DELAY; i++) stage_d[i] <= '0;
        end else if (flush) begin
            stage_v <= '0;
        end else if (enable) begin
            stage_v[0] <= din_valid;
            stage_d[0] <= din;
            for (int i = 1; i < MAX_DELAY; i++) begin
                stage_v[i] <= stage_v[i-1];
                stage_d[i] <= stage_d[i-1];
            end
        end
    end
    always_comb begin
        tap_v = 1'b0;
        dout = '0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (delay_cur == DW'(i + 1)) begin
                tap_v = stage_v[i];
                dout = stage_d[i];
            end
        end
    end
    assign locked = (state == RUN);
    assign dout_valid = tap_v & locked;
endmodule

// File: tb/tb_delay_line_var.sv
// tb_delay_line_var: directed self-checking bench for delay_line_var (8-bit lanes, 4 lanes, max delay 8).
module tb_delay_line_var;
    logic        clk, rst_n, enable, flush, din_valid, dout_valid, locked;
    logic [3:0]  delay_sel, delay_cur;
    logic [31:0] din, dout;
    int vectors = 0;
    int errs = 0;

    delay_line_var #(.BITDATA(8), .LANES(4), .MAX_DELAY(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
        .delay_sel(delay_sel), .din_valid(din_valid), .din(din),
        .dout_valid(dout_valid), .dout(dout), .locked(locked), .delay_cur(delay_cur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rep(input logic [7:0] b);
        return {4{b}};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic en, input logic v, input logic [31:0] d);
        enable = en;
        din_valid = v;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_run(input string tag, input logic exp_l, input logic [31:0] exp_d);
        chk({tag, "_locked"}, 32'(locked), 32'(exp_l));
        chk({tag, "_valid"}, 32'(dout_valid), 32'(exp_l));
        if (exp_l) chk({tag, "_dout"}, dout, exp_d);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; flush = 1'b0; delay_sel = 4'd3; din_valid = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_delay", 32'(delay_cur), 32'd1);
        rst_n = 1'b1;
        // Stalled edge applies delay 3 without a shift, so the fill starts clean.
        tick(1'b0, 1'b0, 32'd0);
        chk("d3_delay", 32'(delay_cur), 32'd3);
        chk("d3_locked", 32'(locked), 32'd0);
        for (int k = 0; k < 12; k++) begin
            tick(1'b1, 1'b1, rep(8'(k)));
            chk_run("fixed3", k >= 2, rep(8'(k - 2)));
        end
        // Stall: delay 4, enable pattern 1,0,0 with words 0x05.. on enabled edges only.
        delay_sel = 4'd4;
        tick(1'b0, 1'b1, rep(8'hEE));
        chk("d4_delay", 32'(delay_cur), 32'd4);
        for (int j = 1; j <= 6; j++) begin
            tick(1'b1, 1'b1, rep(8'(4 + j)));
            chk_run("stall_en", j >= 4, rep(8'(j + 1)));
            for (int s = 0; s < 2; s++) begin
                tick(1'b0, 1'b1, rep(8'hEE));
                chk_run("stall_hold", j >= 4, rep(8'(j + 1)));
            end
        end
        // Delay 2, then change to 5 on an enabled edge mid-stream.
        delay_sel = 4'd2;
        tick(1'b0, 1'b1, rep(8'hEE));
        chk("d2_delay", 32'(delay_cur), 32'd2);
        for (int k = 8'h20; k <= 8'h23; k++) begin
            tick(1'b1, 1'b1, rep(8'(k)));
            chk_run("d2", k >= 8'h21, rep(8'(k - 1)));
        end
        delay_sel = 4'd5;
        for (int k = 8'h24; k <= 8'h2B; k++) begin
            tick(1'b1, 1'b1, rep(8'(k)));
            chk_run("d5", k >= 8'h29, rep(8'(k - 4)));
        end
        chk("d5_delay", 32'(delay_cur), 32'd5);
        // Flush combined with change to delay 4; the flushed-edge word must never appear.
        delay_sel = 4'd4;
        flush = 1'b1;
        tick(1'b1, 1'b1, rep(8'h77));
        flush = 1'b0;
        chk("flush_delay", 32'(delay_cur), 32'd4);
        chk("flush_locked", 32'(locked), 32'd0);
        for (int k = 8'h30; k <= 8'h35; k++) begin
            tick(1'b1, 1'b1, rep(8'(k)));
            chk_run("flush", k >= 8'h33, rep(8'(k - 3)));
        end
        // Saturation low: delay_sel 0 acts as 1; per-lane pattern kept per lane.
        delay_sel = 4'd0;
        tick(1'b0, 1'b0, 32'd0);
        chk("sat0_delay", 32'(delay_cur), 32'd1);
        tick(1'b1, 1'b1, 32'h00FF_5AA5);
        chk_run("sat0", 1'b1, 32'h00FF_5AA5);
        tick(1'b1, 1'b0, 32'h5A00_A5FF);
        chk("sat0_invalid", 32'(dout_valid), 32'd0);
        chk("sat0_data", dout, 32'h5A00_A5FF);
        // Saturation high: 11 clamps to 8.
        delay_sel = 4'd11;
        tick(1'b0, 1'b0, 32'd0);
        chk("sat8_delay", 32'(delay_cur), 32'd8);
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 1'b1, rep(8'(8'h40 + k)));
            chk_run("sat8", k >= 7, rep(8'(8'h40 + k - 7)));
        end
        // Asynchronous reset between edges, then refill at delay 2.
        #3;
        rst_n = 1'b0;
        delay_sel = 4'd2;
        #1;
        chk("arst_valid", 32'(dout_valid), 32'd0);
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_dout", dout, 32'd0);
        chk("arst_delay", 32'(delay_cur), 32'd1);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 1'b1, rep(8'(8'h50 + k)));
            chk_run("refill", k >= 2, rep(8'(8'h50 + k - 1)));
        end
        chk("refill_delay", 32'(delay_cur), 32'd2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/delay_line_var.md
Name: delay_line_var

Overview:
- Multi-lane, runtime-programmable delay pipeline with valid tracking, stall (enable), flush and delay-change relock.
- Successor to the fixed single-lane delay element used for PCIe datapath alignment (lane deskew, pipeline balancing against LTSSM/scrambler latency).
- Delay is selectable per run from 1..MAX_DELAY without resynthesis. Output valid is guaranteed never to present stale or duplicated data across a delay change or flush.

Parameters:
- BITDATA, 8, width of one lane word
- LANES, 4, number of lanes; all lanes share one delay
- MAX_DELAY, 8, maximum delay in enabled cycles (>=1)
- DW, $clog2(MAX_DELAY+1), width of delay select (derived, do not override)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  advance pipeline; 0 = hold all state (stall)
- flush  input  1  synchronous flush; priority over enable
- delay_sel  input  DW  requested delay in enabled cycles
- din_valid  input  1  din qualifier
- din  input  LANES*BITDATA  lane i at bits [i*BITDATA +: BITDATA]
- dout_valid  output  1  dout qualifier
- dout  output  LANES*BITDATA  delayed data
- locked  output  1  1 when the pipeline is filled at the current delay
- delay_cur  output  DW  delay currently applied

Behaviour:
- Saturation: eff_sel = 1 if delay_sel==0; MAX_DELAY if delay_sel>MAX_DELAY; else delay_sel.
- Storage: MAX_DELAY stages, each holding {valid, LANES*BITDATA}. On an enabled edge (enable=1, flush=0), stage0 <= {din_valid,din} and stage[i] <= stage[i-1].
- Output tap: {dout_valid_raw,dout} = stage[delay_cur-1], muxed combinationally from registers.
  - Latency: a word sampled at enabled edge k appears at dout after the k+delay_cur-1 edge, i.e. exactly delay_cur enabled edges later.
  - Stalled cycles do not count toward latency.
- dout_valid = dout_valid_raw AND locked.
- dout is don't-care when dout_valid=0, but must be deterministic (no X after reset).
- Reset (rst_n=0, async):
  - All stage valid bits = 0, stage data = 0.
  - state=FILL, cnt=1, delay_cur=1, locked=0, dout_valid=0, dout=0.
- FSM states: FILL, RUN.
  - FILL: locked=0. Each enabled edge decrements cnt. When cnt==1 on an enabled edge, go RUN next.
  - RUN: locked=1.
- Delay change: at any edge (enable-independent, flush=0) where eff_sel != delay_cur:
  - delay_cur <= eff_sel, cnt <= eff_sel, state <= FILL.
  - Stage contents are kept; output stays qualified off until eff_sel enabled edges have passed, so the new tap holds only post-change-aligned data.
  - If a change coincides with an enabled edge, that shift also occurs. The shift counts toward the new fill only from the next enabled edge.
- Flush (flush=1 at edge):
  - All stage valid bits <= 0 (data unchanged). state <= FILL, cnt <= eff_sel, delay_cur <= eff_sel. No shift.
  - Flush with a simultaneous delay change is a single flush using eff_sel.
- enable=0, flush=0, no delay change: all registers hold. locked and dout are unchanged.
- Reset asserted mid-FILL or mid-RUN returns to the reset values immediately, without waiting for a clock edge.
- Lanes are independent bit slices. No cross-lane arithmetic.
- Formal (FORMAL define): when locked and enable has been high for the last delay_cur edges, dout == $past(din, delay_cur) and dout_valid == $past(din_valid, delay_cur).

Test Plan:
- Reset then fixed delay: delay_sel=3, enable=1, din=incrementing 0x00..0x1F on all lanes, valid=1 -> locked rises after the 3rd enabled edge; dout equals din from 3 edges earlier; dout_valid=0 for the first 3 cycles.
- Stall: delay_sel=4, enable toggled 1,0,0,1,... -> dout advances only on enabled edges; word 0x05 emerges 4 enabled edges after capture; held constant while enable=0.
- Delay change in RUN: delay 2 -> 5 mid-stream -> locked=0, dout_valid=0 for exactly 5 enabled edges; then dout == din delayed by 5, with no duplicate or skipped word.
- Flush: in RUN at delay 4, assert flush for one cycle with din_valid=1 -> next 4 enabled edges have dout_valid=0; the first valid output is the first word captured after the flush.
- Saturation/bounds: delay_sel=0 -> delay_cur=1, 1-cycle latency. delay_sel=MAX_DELAY+3 (e.g. 11 with MAX=8) -> delay_cur=8. Per-lane pattern 0xA5/0x5A/0xFF/0x00 preserved per lane.
- Async reset mid-RUN: drop rst_n between clock edges -> dout_valid, locked and dout go to 0 immediately; after release the pipeline refills and locks per the current delay_sel.
